// File: rtl/poly_arith_writeback_pkg.sv
// Shared NTT control definitions: write-back FSM states and the
// polynomial geometry helpers used to size counters and addresses.
package poly_arith_writeback_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } wb_state_e;

    // Words per polynomial: N/2 coefficients pairs spread over PE lanes.
    // Degenerate parameter values collapse to a single word.
    function automatic int unsigned calc_w(input int unsigned logn, input int unsigned pe);
        int unsigned n;
        int unsigned lanes;
        int unsigned w;
        n     = 32'd1 << logn;
        lanes = (pe == 0) ? 1 : pe;
        w     = n / 2 / lanes;
        return (w == 0) ? 1 : w;
    endfunction

    // Word-counter width; kept at least one bit so the counter always exists.
    function automatic int unsigned calc_cw(input int unsigned logn, input int unsigned pe);
        int unsigned c;
        c = $clog2(calc_w(logn, pe));
        return (c == 0) ? 1 : c;
    endfunction

    // Memory word-address width covering every polynomial slot.
    function automatic int unsigned calc_aw(input int unsigned logn, input int unsigned pe,
                                            input int unsigned num_poly);
        int unsigned slots;
        int unsigned a;
        slots = (num_poly == 0) ? 1 : num_poly;
        a     = $clog2(slots * calc_w(logn, pe));
        return (a == 0) ? 1 : a;
    endfunction

endpackage

// File: rtl/poly_arith_writeback.sv
// Polynomial write-back sequencer: turns the datapath's result-valid stream
// into one memory write per result word, W words per armed polynomial.
module poly_arith_writeback
    import poly_arith_writeback_pkg::*;
#(
    parameter int unsigned LOGN     = 0,
    parameter int unsigned PE       = 0,
    parameter int unsigned NUM_POLY = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [calc_aw(LOGN, PE, NUM_POLY)-1:0]   poly_base_c,
    input  logic                                     res_valid,
    input  logic                                     res_swap,
    output logic                                     wr_en,
    output logic [calc_aw(LOGN, PE, NUM_POLY)-1:0]   wr_addr,
    output logic                                     wr_swap,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     overrun
);

    localparam int unsigned W  = calc_w(LOGN, PE);
    localparam int unsigned CW = calc_cw(LOGN, PE);
    localparam int unsigned AW = calc_aw(LOGN, PE, NUM_POLY);

    wb_state_e         state_q;
    logic [CW-1:0]     count_q;
    logic [AW-1:0]     base_q;

    // FSM with registered outputs; done is issued from FIN so it lands one
    // cycle after the final write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            base_q  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_swap <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy <= 1'b0;
                    // busy still high here means this is the done cycle; start is ignored
                    if (start && !busy) begin
                        base_q  <= poly_base_c;
                        count_q <= '0;
                        overrun <= res_valid;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else if (res_valid) begin
                        overrun <= 1'b1;
                    end
                end
                StRun: begin
                    if (res_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= base_q + AW'(count_q);
                        wr_swap <= res_swap;
                        if (count_q == CW'(W - 1)) begin
                            count_q <= '0;
                            state_q <= StFin;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                StFin: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                    if (res_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_arith_writeback.sv
// Randomised and directed self-checking bench for poly_arith_writeback.
module tb_poly_arith_writeback;

    localparam int unsigned LOGN     = 8;
    localparam int unsigned PE       = 4;
    localparam int unsigned NUM_POLY = 4;
    localparam int unsigned W        = 32;
    localparam int unsigned AW       = 7;
    localparam int unsigned DEPTH    = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] poly_base_c;
    logic          res_valid;
    logic          res_swap;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_swap;
    logic          busy;
    logic          done;
    logic          overrun;

    poly_arith_writeback #(
        .LOGN    (LOGN),
        .PE      (PE),
        .NUM_POLY(NUM_POLY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .poly_base_c(poly_base_c),
        .res_valid  (res_valid),
        .res_swap   (res_swap),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_swap    (wr_swap),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    bit cmp_en = 1'b0;

    int log_addr[$];
    int log_swap[$];
    int done_cnt;
    int last_wr_cyc;
    int done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Reference model: an armed polynomial accepts W results, each landing
    // one cycle later at (base + index) mod DEPTH; afterwards a two-cycle
    // tail (last-write+1 quiet, last-write+2 done) keeps the block busy.
    logic m_armed;
    int   m_base;
    int   m_writes;
    int   m_tail;
    logic e_wr_en;
    int   e_addr;
    logic e_swap;
    logic e_busy;
    logic e_done;
    logic e_ovr;

    always @(posedge clk) begin
        if (rst) begin
            m_armed  <= 1'b0;
            m_base   <= 0;
            m_writes <= 0;
            m_tail   <= 0;
            e_wr_en  <= 1'b0;
            e_addr   <= 0;
            e_swap   <= 1'b0;
            e_busy   <= 1'b0;
            e_done   <= 1'b0;
            e_ovr    <= 1'b0;
        end else begin
            e_wr_en <= m_armed && res_valid;
            e_done  <= (m_tail == 2);
            if (m_armed && res_valid) begin
                e_addr <= (m_base + m_writes) % DEPTH;
                e_swap <= res_swap;
            end
            if (!m_armed && m_tail == 0 && start) begin
                m_armed  <= 1'b1;
                m_base   <= int'(poly_base_c);
                m_writes <= 0;
                e_ovr    <= res_valid;
                e_busy   <= 1'b1;
            end else if (m_armed) begin
                if (res_valid) begin
                    if (m_writes == W - 1) begin
                        m_armed  <= 1'b0;
                        m_tail   <= 2;
                        m_writes <= 0;
                    end else begin
                        m_writes <= m_writes + 1;
                    end
                end
                e_busy <= 1'b1;
            end else begin
                if (res_valid) e_ovr <= 1'b1;
                if (m_tail > 0) m_tail <= m_tail - 1;
                e_busy <= (m_tail == 2);
            end
        end
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Cycle compare against the model, plus logging for literal checks.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wr_en",   wr_en,   e_wr_en);
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_swap", wr_swap, e_swap);
            chk("busy",    busy,    e_busy);
            chk("done",    done,    e_done);
            chk("overrun", overrun, e_ovr);
            if (wr_en) begin
                log_addr.push_back(int'(wr_addr));
                log_swap.push_back(int'(wr_swap));
                last_wr_cyc = cyc_cnt;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc_cnt;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_swap.delete();
        done_cnt    = 0;
        last_wr_cyc = -1;
        done_cyc    = -1;
    endtask

    // One full write-back: start, W results (optionally gapped), then drain.
    task automatic run(input int base, input bit gapped, input bit alt_swap, input int restart_at);
        start       = 1'b1;
        poly_base_c = AW'(base);
        cyc();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            res_valid = 1'b1;
            res_swap  = alt_swap ? 1'(i % 2) : 1'($urandom_range(0, 1));
            if (i == restart_at) begin
                start       = 1'b1;
                poly_base_c = '0;
            end
            cyc();
            start     = 1'b0;
            res_valid = 1'b0;
            if (gapped) cyc();
        end
        res_valid = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        poly_base_c = '0;
        res_valid   = 1'b0;
        res_swap    = 1'b0;
        clear_log();
        cyc();
        cyc();
        cmp_en = 1'b1;
        chk("reset_wr_en", wr_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);
        rst = 1'b0;
        cyc();

        // Back-to-back run at base 64.
        clear_log();
        run(64, 1'b0, 1'b0, -1);
        chk("t1_count", log_addr.size(), 32);
        chk("t1_first", log_addr[0], 64);
        chk("t1_last", log_addr[31], 95);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_lag", done_cyc - last_wr_cyc, 1);
        chk("t1_busy_after", busy, 0);
        chk("t1_overrun", overrun, 0);

        // Gapped run at base 0 with alternating lane order.
        clear_log();
        run(0, 1'b1, 1'b1, -1);
        chk("t2_count", log_addr.size(), 32);
        chk("t2_addr7", log_addr[7], 7);
        chk("t2_last", log_addr[31], 31);
        chk("t2_swap3", log_swap[3], 1);
        chk("t2_swap4", log_swap[4], 0);

        // Address wrap from base 112.
        clear_log();
        run(112, 1'b0, 1'b0, -1);
        chk("t3_addr15", log_addr[15], 127);
        chk("t3_addr16", log_addr[16], 0);
        chk("t3_last", log_addr[31], 15);

        // Result with nowhere to go, then cleared by the next start.
        res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
        cyc();
        chk("t4_overrun_set", overrun, 1);
        chk("t4_model_ovr", e_ovr, 1);
        clear_log();
        run(8, 1'b0, 1'b0, -1);
        chk("t4_overrun_clr", overrun, 0);
        chk("t4_count", log_addr.size(), 32);

        // Reset in the middle of a run.
        clear_log();
        start       = 1'b1;
        poly_base_c = '0;
        cyc();
        start = 1'b0;
        repeat (10) begin
            res_valid = 1'b1;
            res_swap  = 1'b1;
            cyc();
        end
        res_valid = 1'b0;
        rst       = 1'b1;
        cyc();
        chk("t5_wr_en", wr_en, 0);
        chk("t5_addr", wr_addr, 0);
        chk("t5_swap", wr_swap, 0);
        chk("t5_busy", busy, 0);
        rst = 1'b0;
        repeat (3) cyc();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_writes", log_addr.size(), 10);
        clear_log();
        run(32, 1'b0, 1'b0, -1);
        chk("t5_restart_first", log_addr[0], 32);
        chk("t5_restart_last", log_addr[31], 63);

        // Second start mid-run is ignored.
        clear_log();
        run(64, 1'b0, 1'b0, 5);
        chk("t6_count", log_addr.size(), 32);
        chk("t6_addr5", log_addr[5], 69);
        chk("t6_last", log_addr[31], 95);
        chk("t6_done_cnt", done_cnt, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            start       = ($urandom_range(0, 15) == 0);
            poly_base_c = AW'($urandom);
            res_valid   = ($urandom_range(0, 3) != 0);
            res_swap    = 1'($urandom_range(0, 1));
            cyc();
        end
        rst       = 1'b0;
        start     = 1'b0;
        res_valid = 1'b0;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
